// File: rtl/regfile_wb_arbiter.sv
// Round-robin writeback arbiter for the single regfile write port.
// Optional WB_BYPASS_EN forwards the registered write to decode operands.
module regfile_wb_arbiter #(
    parameter int NREQ = 3,
    parameter int XLEN = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      wb_valid,
    input  logic [5*NREQ-1:0]    wb_rd,
    input  logic [XLEN*NREQ-1:0] wb_data,
    output logic [NREQ-1:0]      wb_ready,
    input  logic                 issue_valid,
    input  logic [4:0]           issue_rd,
    output logic                 issue_ready,
    input  logic                 flush,
    input  logic [4:0]           rs1,
    input  logic [4:0]           rs2,
    input  logic                 rs1_used,
    input  logic                 rs2_used,
    input  logic [XLEN-1:0]      rf_read_data1,
    input  logic [XLEN-1:0]      rf_read_data2,
    output logic [XLEN-1:0]      fwd_data1,
    output logic [XLEN-1:0]      fwd_data2,
    output logic                 hazard,
    output logic [4:0]           wright_reg,
    output logic [XLEN-1:0]      wright_data,
    output logic                 wright_en
);

    logic [1:0]      last_q, last_d;
    logic [2:0]      gnt;
    logic [1:0]      gsel;
    logic            xfer;
    logic [4:0]      sel_rd;
    logic [XLEN-1:0] sel_data;
    logic            wen_q, wen_d;
    logic [4:0]      wreg_q, wreg_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [31:0]     busy_q, busy_d;
    logic            hit1, hit2, inflight;

    // Search starts just after the last granted requester and wraps.
    always_comb begin
        gnt = 3'b000;
        unique case (last_q)
            2'd0: begin
                if (wb_valid[1])      gnt = 3'b010;
                else if (wb_valid[2]) gnt = 3'b100;
                else if (wb_valid[0]) gnt = 3'b001;
            end
            2'd1: begin
                if (wb_valid[2])      gnt = 3'b100;
                else if (wb_valid[0]) gnt = 3'b001;
                else if (wb_valid[1]) gnt = 3'b010;
            end
            default: begin
                if (wb_valid[0])      gnt = 3'b001;
                else if (wb_valid[1]) gnt = 3'b010;
                else if (wb_valid[2]) gnt = 3'b100;
            end
        endcase
    end

    assign wb_ready = gnt;
    assign xfer     = |gnt;

    always_comb begin
        gsel     = 2'd0;
        sel_rd   = wb_rd[4:0];
        sel_data = wb_data[XLEN-1:0];
        unique case (1'b1)
            gnt[1]: begin
                gsel     = 2'd1;
                sel_rd   = wb_rd[9:5];
                sel_data = wb_data[2*XLEN-1:XLEN];
            end
            gnt[2]: begin
                gsel     = 2'd2;
                sel_rd   = wb_rd[14:10];
                sel_data = wb_data[3*XLEN-1:2*XLEN];
            end
            default: ;
        endcase
    end

    assign last_d  = xfer ? gsel : last_q;
    assign wen_d   = xfer && (sel_rd != 5'd0);
    assign wreg_d  = xfer ? sel_rd : wreg_q;
    assign wdata_d = xfer ? sel_data : wdata_q;

    assign issue_ready = !busy_q[issue_rd];

    // A same-edge issue outranks the writeback clear; flush outranks both.
    always_comb begin
        busy_d = busy_q;
        if (xfer) busy_d[sel_rd] = 1'b0;
        if (flush) begin
            busy_d = '0;
        end else if (issue_valid && issue_ready && issue_rd != 5'd0) begin
            busy_d[issue_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q  <= 2'd2;
            wen_q   <= 1'b0;
            wreg_q  <= '0;
            wdata_q <= '0;
            busy_q  <= '0;
        end else begin
            last_q  <= last_d;
            wen_q   <= wen_d;
            wreg_q  <= wreg_d;
            wdata_q <= wdata_d;
            busy_q  <= busy_d;
        end
    end

    assign wright_en   = wen_q;
    assign wright_reg  = wreg_q;
    assign wright_data = wdata_q;

    assign hit1 = wen_q && (wreg_q == rs1) && (rs1 != 5'd0);
    assign hit2 = wen_q && (wreg_q == rs2) && (rs2 != 5'd0);

`ifdef WB_BYPASS_EN
    assign fwd_data1 = hit1 ? wdata_q : rf_read_data1;
    assign fwd_data2 = hit2 ? wdata_q : rf_read_data2;
    assign inflight  = 1'b0;
`else
    // Regfile commits one edge after wright_en, so stall that extra cycle.
    assign fwd_data1 = rf_read_data1;
    assign fwd_data2 = rf_read_data2;
    assign inflight  = (rs1_used && hit1) || (rs2_used && hit2);
`endif

    assign hazard = (rs1_used && busy_q[rs1])
                 || (rs2_used && busy_q[rs2])
                 || inflight;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed and randomized bench for regfile_wb_arbiter.
// Expected values come from a behavioural model of the arbiter rules.
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  wb_valid;
    logic [14:0] wb_rd;
    logic [95:0] wb_data;
    logic [2:0]  wb_ready;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic        issue_ready;
    logic        flush;
    logic [4:0]  rs1, rs2;
    logic        rs1_used, rs2_used;
    logic [31:0] rf_read_data1, rf_read_data2;
    logic [31:0] fwd_data1, fwd_data2;
    logic        hazard;
    logic [4:0]  wright_reg;
    logic [31:0] wright_data;
    logic        wright_en;

    int checks = 0;
    int errors = 0;

    bit          m_busy [32];
    int          m_last;
    int          m_lastg;
    logic        m_wen;
    logic [4:0]  m_wreg;
    logic [31:0] m_wdata;

    regfile_wb_arbiter #(.NREQ(3), .XLEN(32)) dut (
        .clk(clk), .rst(rst),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .wb_ready(wb_ready),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .issue_ready(issue_ready), .flush(flush),
        .rs1(rs1), .rs2(rs2), .rs1_used(rs1_used), .rs2_used(rs2_used),
        .rf_read_data1(rf_read_data1), .rf_read_data2(rf_read_data2),
        .fwd_data1(fwd_data1), .fwd_data2(fwd_data2), .hazard(hazard),
        .wright_reg(wright_reg), .wright_data(wright_data),
        .wright_en(wright_en)
    );

    always #5 clk = ~clk;

    function automatic int exp_grant();
        for (int k = 0; k < 3; k++) begin
            int i;
            i = (m_last + 1 + k) % 3;
            if (wb_valid[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [2:0] exp_ready();
        int g;
        g = exp_grant();
        return (g < 0) ? 3'b000 : 3'(1 << g);
    endfunction

    function automatic logic exp_hazard();
        logic h;
        h = (rs1_used && rs1 != 0 && m_busy[rs1])
         || (rs2_used && rs2 != 0 && m_busy[rs2]);
`ifndef WB_BYPASS_EN
        h = h || (m_wen && ((rs1_used && rs1 != 0 && m_wreg == rs1)
                         || (rs2_used && rs2 != 0 && m_wreg == rs2)));
`endif
        return h;
    endfunction

    function automatic logic [31:0] exp_fwd(logic [4:0] rs,
                                             logic [31:0] rf);
`ifdef WB_BYPASS_EN
        if (m_wen && rs != 0 && m_wreg == rs) return m_wdata;
`endif
        return rf;
    endfunction

    // Advance the model by one clock edge using the current inputs.
    task automatic tick();
        int          g;
        bit          nb [32];
        bit          ir;
        logic [4:0]  rd;
        g  = exp_grant();
        nb = m_busy;
        ir = (issue_rd == 0) || !m_busy[issue_rd];
        @(posedge clk);
        if (rst) begin
            foreach (m_busy[i]) m_busy[i] = 0;
            m_last = 2; m_lastg = -1;
            m_wen = 0; m_wreg = 0; m_wdata = 0;
        end else begin
            m_lastg = g;
            if (g >= 0) begin
                rd      = wb_rd[5*g +: 5];
                m_wen   = (rd != 0);
                m_wreg  = rd;
                m_wdata = wb_data[32*g +: 32];
                m_last  = g;
                nb[rd]  = 0;
            end else begin
                m_wen = 0;
            end
            if (flush) foreach (nb[i]) nb[i] = 0;
            else if (issue_valid && ir && issue_rd != 0) nb[issue_rd] = 1;
            nb[0]  = 0;
            m_busy = nb;
        end
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic idle_inputs();
        wb_valid = 0; wb_rd = 0; wb_data = 0;
        issue_valid = 0; issue_rd = 0; flush = 0;
        rs1 = 0; rs2 = 0; rs1_used = 0; rs2_used = 0;
        rf_read_data1 = 0; rf_read_data2 = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        tick();
        rst = 0;
    endtask

    task automatic test_reset();
        do_reset();
        issue_rd = 5; rs1 = 5; rs1_used = 1;
        settle();
        checks++;
        if (wright_en !== 1'b0) begin
            errors++; $display("FAIL rst_wen got %b exp 0", wright_en);
        end
        checks++;
        if (wright_reg !== 5'd0 || wright_data !== 32'd0) begin
            errors++;
            $display("FAIL rst_wreg got %h/%h exp 0/0",
                     wright_reg, wright_data);
        end
        checks++;
        if (wb_ready !== 3'b000) begin
            errors++; $display("FAIL rst_ready got %b exp 000", wb_ready);
        end
        checks++;
        if (issue_ready !== 1'b1 || hazard !== 1'b0) begin
            errors++;
            $display("FAIL rst_busy got ir=%b hz=%b exp ir=1 hz=0",
                     issue_ready, hazard);
        end
    endtask

    task automatic test_single_alu();
        do_reset();
        wb_valid = 3'b001; wb_rd[4:0] = 5; wb_data[31:0] = 32'h1234;
        settle();
        checks++;
        if (wb_ready !== 3'b001) begin
            errors++; $display("FAIL alu_ready got %b exp 001", wb_ready);
        end
        tick();
        wb_valid = 0;
        settle();
        checks++;
        if (wright_en !== 1'b1 || wright_reg !== 5'd5
            || wright_data !== 32'h1234) begin
            errors++;
            $display("FAIL alu_write got %b/%0d/%h exp 1/5/00001234",
                     wright_en, wright_reg, wright_data);
        end
        tick();
        checks++;
        if (wright_en !== 1'b0) begin
            errors++; $display("FAIL alu_wen_drop got %b exp 0", wright_en);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        wb_valid = 3'b111;
        wb_rd    = {5'd3, 5'd2, 5'd1};
        wb_data  = {32'hC, 32'hB, 32'hA};
        for (int i = 0; i < 6; i++) begin
            settle();
            checks++;
            if (wb_ready !== 3'(1 << (i % 3))) begin
                errors++;
                $display("FAIL rr_grant[%0d] got %b exp %b",
                         i, wb_ready, 3'(1 << (i % 3)));
            end
            tick();
            checks++;
            if (wright_reg !== 5'(i % 3 + 1)) begin
                errors++;
                $display("FAIL rr_wreg[%0d] got %0d exp %0d",
                         i, wright_reg, i % 3 + 1);
            end
        end
    endtask

    task automatic test_raw_hazard();
        do_reset();
        issue_valid = 1; issue_rd = 7;
        tick();
        issue_valid = 0;
        rs1 = 7; rs1_used = 1; rf_read_data1 = 32'h1111;
        settle();
        checks++;
        if (hazard !== 1'b1 || issue_ready !== 1'b0) begin
            errors++;
            $display("FAIL raw_busy got hz=%b ir=%b exp hz=1 ir=0",
                     hazard, issue_ready);
        end
        wb_valid = 3'b010; wb_rd[9:5] = 7; wb_data[63:32] = 32'hCAFE;
        settle();
        checks++;
        if (wb_ready !== 3'b010) begin
            errors++; $display("FAIL raw_mem_ready got %b exp 010", wb_ready);
        end
        tick();
        wb_valid = 0;
        settle();
        checks++;
        if (issue_ready !== 1'b1) begin
            errors++; $display("FAIL raw_clear got %b exp 1", issue_ready);
        end
`ifdef WB_BYPASS_EN
        checks++;
        if (hazard !== 1'b0 || fwd_data1 !== 32'hCAFE) begin
            errors++;
            $display("FAIL raw_bypass got hz=%b fwd=%h exp hz=0 fwd=cafe",
                     hazard, fwd_data1);
        end
`else
        checks++;
        if (hazard !== 1'b1 || fwd_data1 !== 32'h1111) begin
            errors++;
            $display("FAIL raw_inflight got hz=%b fwd=%h exp hz=1 fwd=1111",
                     hazard, fwd_data1);
        end
`endif
        tick();
        checks++;
        if (hazard !== 1'b0) begin
            errors++; $display("FAIL raw_done got %b exp 0", hazard);
        end
    endtask

    task automatic test_set_wins();
        do_reset();
        wb_valid = 3'b001; wb_rd[4:0] = 9; wb_data[31:0] = 32'h5;
        issue_valid = 1; issue_rd = 9;
        settle();
        tick();
        wb_valid = 0; issue_valid = 0;
        rs1 = 9; rs1_used = 1;
        settle();
        checks++;
        if (issue_ready !== 1'b0 || hazard !== 1'b1) begin
            errors++;
            $display("FAIL set_wins got ir=%b hz=%b exp ir=0 hz=1",
                     issue_ready, hazard);
        end
    endtask

    task automatic test_rd0();
        do_reset();
        wb_valid = 3'b100; wb_data[95:64] = 32'hFFFF_FFFF;
        issue_valid = 1; issue_rd = 0;
        settle();
        checks++;
        if (wb_ready !== 3'b100 || issue_ready !== 1'b1) begin
            errors++;
            $display("FAIL rd0_accept got rdy=%b ir=%b exp rdy=100 ir=1",
                     wb_ready, issue_ready);
        end
        tick();
        wb_valid = 0; issue_valid = 0;
        rs1 = 0; rs1_used = 1;
        settle();
        checks++;
        if (wright_en !== 1'b0 || hazard !== 1'b0) begin
            errors++;
            $display("FAIL rd0_discard got wen=%b hz=%b exp 0/0",
                     wright_en, hazard);
        end
    endtask

    task automatic test_flush();
        logic [4:0] regs [3];
        regs = '{5'd3, 5'd4, 5'd6};
        do_reset();
        issue_valid = 1; issue_rd = 3;
        tick();
        issue_rd = 4;
        tick();
        issue_valid = 0;
        wb_valid = 3'b001; wb_rd[4:0] = 10; wb_data[31:0] = 32'hABCD;
        tick();
        wb_valid = 0; flush = 1; issue_valid = 1; issue_rd = 6;
        settle();
        checks++;
        if (wright_en !== 1'b1 || wright_reg !== 5'd10) begin
            errors++;
            $display("FAIL flush_inflight got %b/%0d exp 1/10",
                     wright_en, wright_reg);
        end
        tick();
        flush = 0; issue_valid = 0;
        foreach (regs[i]) begin
            issue_rd = regs[i];
            settle();
            checks++;
            if (issue_ready !== 1'b1) begin
                errors++;
                $display("FAIL flush_busy[%0d] got %b exp 1",
                         regs[i], issue_ready);
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        wb_valid = 3'b111;
        wb_rd    = {5'd3, 5'd2, 5'd1};
        tick();
        tick();
        rst = 1;
        tick();
        rst = 0;
        settle();
        checks++;
        if (wright_en !== 1'b0 || wb_ready !== 3'b001) begin
            errors++;
            $display("FAIL rst_mid got wen=%b rdy=%b exp 0/001",
                     wright_en, wb_ready);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < 3; i++) begin
                if (!wb_valid[i] || i == m_lastg) begin
                    wb_valid[i]     = ($urandom_range(0, 1) == 1);
                    wb_rd[5*i +: 5] = 5'($urandom_range(0, 7));
                    wb_data[32*i +: 32] = $urandom;
                end
            end
            issue_valid   = ($urandom_range(0, 2) == 0);
            issue_rd      = 5'($urandom_range(0, 7));
            flush         = ($urandom_range(0, 19) == 0);
            rs1           = 5'($urandom_range(0, 7));
            rs2           = 5'($urandom_range(0, 7));
            rs1_used      = ($urandom_range(0, 1) == 1);
            rs2_used      = ($urandom_range(0, 1) == 1);
            rf_read_data1 = $urandom;
            rf_read_data2 = $urandom;
            settle();
            checks++;
            if (wb_ready !== exp_ready()) begin
                errors++;
                $display("FAIL rnd_ready c=%0d got %b exp %b",
                         c, wb_ready, exp_ready());
            end
            checks++;
            if (issue_ready !== (issue_rd == 0 || !m_busy[issue_rd])) begin
                errors++;
                $display("FAIL rnd_issue c=%0d got %b", c, issue_ready);
            end
            checks++;
            if (hazard !== exp_hazard()) begin
                errors++;
                $display("FAIL rnd_hazard c=%0d got %b exp %b",
                         c, hazard, exp_hazard());
            end
            checks++;
            if (fwd_data1 !== exp_fwd(rs1, rf_read_data1)
                || fwd_data2 !== exp_fwd(rs2, rf_read_data2)) begin
                errors++;
                $display("FAIL rnd_fwd c=%0d got %h/%h exp %h/%h",
                         c, fwd_data1, fwd_data2,
                         exp_fwd(rs1, rf_read_data1),
                         exp_fwd(rs2, rf_read_data2));
            end
            checks++;
            if (wright_en !== m_wen || wright_reg !== m_wreg
                || wright_data !== m_wdata) begin
                errors++;
                $display("FAIL rnd_wport c=%0d got %b/%0d/%h exp %b/%0d/%h",
                         c, wright_en, wright_reg, wright_data,
                         m_wen, m_wreg, m_wdata);
            end
            tick();
        end
    endtask

    initial begin
        idle_inputs();
        rst = 1;
        m_last = 2; m_lastg = -1;
        m_wen = 0; m_wreg = 0; m_wdata = 0;
        foreach (m_busy[i]) m_busy[i] = 0;
        test_reset();
        test_single_alu();
        test_round_robin();
        test_raw_hazard();
        test_set_wins();
        test_rd0();
        test_flush();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
